// File: rtl/mips_bus_lsu_if.sv
// Core-request / memory-bus signal bundle for the MIPS load/store unit.
// The 'master' modport is the LSU itself because it masters the memory bus.
// The 'slave' modport is the environment, meaning the core plus the memory responder.
interface mips_bus_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_bus_lsu.sv
// MIPS load/store unit: turns one core request into a single word-addressed
// bus access with byte enables, then returns extended load data.
// The fixed read latency is one cycle.
// Optional feature macro: LSU_ALIGN_CHECK_EN.
//   Defined:   misaligned halfword/word accesses return resp_err=1 and never reach the bus.
//   Undefined: resp_err is tied to 0, and the low address bits are truncated to the access size.
module mips_bus_lsu (
  input  logic           clk,
  input  logic           reset,
  mips_bus_lsu_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} state_t;
  typedef enum logic [2:0] {
    OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3,
    OP_LW = 3'd4, OP_SB  = 3'd5, OP_SH = 3'd6, OP_SW  = 3'd7
  } op_t;

  state_t      state, state_nx;
  op_t         op_in, op_q;
  logic [1:0]  off_in, off_q;
  logic [3:0]  be_in, be_q;
  logic [31:0] wd_in, wdata_q, addr_q, rdata_q, load_ext;
  logic        err_q, misalign, accept, store_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign op_in   = op_t'(bus.req_op);
  assign accept  = bus.req_valid && (state == IDLE);
  assign store_q = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

  // Decode the incoming request into its lane offset, byte enables and replicated write data.
  always_comb begin
    misalign = 1'b0;
    off_in   = bus.req_addr[1:0];
`ifdef LSU_ALIGN_CHECK_EN
    case (op_in)
      OP_LH, OP_LHU, OP_SH: misalign = bus.req_addr[0];
      OP_LW, OP_SW:         misalign = (bus.req_addr[1:0] != 2'b00);
      default:              misalign = 1'b0;
    endcase
`else
    case (op_in)
      OP_LH, OP_LHU, OP_SH: off_in = {bus.req_addr[1], 1'b0};
      OP_LW, OP_SW:         off_in = 2'b00;
      default:              off_in = bus.req_addr[1:0];
    endcase
`endif
    be_in = 4'b1111;
    wd_in = bus.req_wdata;
    case (op_in)
      OP_SB: begin
        be_in = 4'b0001 << off_in;
        wd_in = {4{bus.req_wdata[7:0]}};
      end
      OP_SH: begin
        be_in = off_in[1] ? 4'b1100 : 4'b0011;
        wd_in = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be_in = 4'b1111;
        wd_in = bus.req_wdata;
      end
    endcase
  end

  // Select the addressed lane(s) of readdata, then sign- or zero-extend them to 32 bits.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = bus.readdata[7:0];
      2'd1:    byte_sel = bus.readdata[15:8];
      2'd2:    byte_sel = bus.readdata[23:16];
      default: byte_sel = bus.readdata[31:24];
    endcase
    half_sel = off_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'd0, byte_sel};
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'd0, half_sel};
      default: load_ext = bus.readdata;
    endcase
  end

  // Hold the FSM state register, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Compute the next state: an aligned request goes to the bus, a misaligned one goes straight to the response.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = misalign ? RESP : BUS;
      BUS:     if (!bus.waitrequest) state_nx = store_q ? RESP : RDATA;
      RDATA:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Register the request on acceptance, and capture the extended read data at the end of RDATA.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= OP_LB;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= op_in;
      off_q   <= off_in;
      addr_q  <= {bus.req_addr[31:2], 2'b00};
      wdata_q <= wd_in;
      be_q    <= be_in;
      rdata_q <= '0;
      err_q   <= misalign;
    end else if (state == RDATA) begin
      rdata_q <= load_ext;
    end
  end

  // Drive outputs from the state: strobes only in BUS, response fields gated by RESP.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.read       = (state == BUS) && !store_q;
    bus.write      = (state == BUS) && store_q;
    bus.address    = addr_q;
    bus.writedata  = wdata_q;
    bus.byteenable = be_q;
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = (state == RESP) ? rdata_q : '0;
    bus.resp_err   = (state == RESP) ? err_q : 1'b0;
  end
endmodule

// File: tb/tb_mips_bus_lsu.sv
// Self-checking bench for mips_bus_lsu.
// It pushes the expected bus beats and responses into queues as each request is issued.
// The two monitors pop those queues and compare them against what the DUT produces.
module tb_mips_bus_lsu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_bus_lsu_if lif ();

  mips_bus_lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lif)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        wr;
    int          cycles;
  } bus_exp_t;

  resp_exp_t rexp_q[$];
  bus_exp_t  bexp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int resp_seen = 0;
  int wait_cfg = 0;
  logic [31:0] rd_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Bus responder and monitor: applies the wait states, returns readdata one cycle after the read, and checks each beat.
  bit          in_bus = 1'b0;
  bit          rd_next = 1'b0;
  int          wait_left = 0;
  int          strobe_cycles = 0;
  bus_exp_t    bcur;
  logic [31:0] snap_addr, snap_wd;
  logic [3:0]  snap_be;
  always @(negedge clk) begin
    lif.readdata = rd_next ? rd_val : 32'h5A5A_A5A5;
    rd_next = 1'b0;
    lif.waitrequest = 1'b0;
    if (lif.read || lif.write) begin
      check("rw_exclusive", {31'd0, lif.read && lif.write}, 32'd0);
      if (!in_bus) begin
        in_bus = 1'b1;
        strobe_cycles = 0;
        wait_left = wait_cfg;
        if (bexp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
          bcur = '{32'd0, 4'd0, 32'd0, 1'b0, 0};
        end else begin
          bcur = bexp_q.pop_front();
          check("bus_addr", lif.address, bcur.addr);
          check("bus_be", {28'd0, lif.byteenable}, {28'd0, bcur.be});
          check("bus_write", {31'd0, lif.write}, {31'd0, bcur.wr});
          if (bcur.wr) check("bus_wdata", lif.writedata, bcur.wd);
        end
        snap_addr = lif.address;
        snap_wd   = lif.writedata;
        snap_be   = lif.byteenable;
      end else begin
        check("hold_addr", lif.address, snap_addr);
        check("hold_wdata", lif.writedata, snap_wd);
        check("hold_be", {28'd0, lif.byteenable}, {28'd0, snap_be});
      end
      strobe_cycles++;
      if (wait_left > 0) begin
        lif.waitrequest = 1'b1;
        wait_left--;
      end else if (lif.read) begin
        rd_next = 1'b1;
      end
    end else if (in_bus) begin
      in_bus = 1'b0;
      check("strobe_cycles", strobe_cycles, bcur.cycles);
    end
  end

  // Response monitor: pops the expected response on every resp_valid pulse and checks that the fields are zero otherwise.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (lif.resp_valid) begin
        if (rexp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          resp_exp_t e;
          e = rexp_q.pop_front();
          check("resp_rdata", lif.resp_rdata, e.rdata);
          check("resp_err", {31'd0, lif.resp_err}, {31'd0, e.err});
          check("resp_latency", cyc - e.acc + 1, e.lat);
        end
        resp_seen++;
      end else begin
        check("resp_idle_zero", {lif.resp_rdata[31:1], lif.resp_rdata[0] | lif.resp_err}, 32'd0);
      end
    end
  end

  task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rd, input int waits,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input bit has_bus, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd);
    int start;
    int t;
    @(negedge clk);
    wait_cfg = waits;
    rd_val   = rd;
    if (has_bus) bexp_q.push_back('{exp_addr, exp_be, exp_wd, (op >= 3'd5), waits + 1});
    lif.req_valid = 1'b1;
    lif.req_op    = op;
    lif.req_addr  = addr;
    lif.req_wdata = wdata;
    check("ready_idle", {31'd0, lif.req_ready}, 32'd1);
    start = resp_seen;
    @(posedge clk);
    #1;
    lif.req_valid = 1'b0;
    lif.req_wdata = 32'hDEAD_0000;
    rexp_q.push_back('{exp_rdata, exp_err, exp_lat, cyc});
    check("ready_busy", {31'd0, lif.req_ready}, 32'd0);
    t = 0;
    while (resp_seen == start && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (resp_seen == start) begin
      check("resp_timeout", 32'd0, 32'd1);
      rexp_q.delete();
    end
  endtask

  // A load stalled by waitrequest is abandoned by reset: the strobe must drop and no response may follow.
  task automatic abort_test();
    @(negedge clk);
    wait_cfg = 10;
    bexp_q.push_back('{32'hBFC0_0020, 4'b1111, 32'd0, 1'b0, 2});
    lif.req_valid = 1'b1;
    lif.req_op    = 3'd4;
    lif.req_addr  = 32'hBFC0_0020;
    @(posedge clk);
    #1;
    lif.req_valid = 1'b0;
    @(negedge clk);
    check("abort_read_on", {31'd0, lif.read}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_read_off", {31'd0, lif.read}, 32'd0);
    check("abort_no_resp", {31'd0, lif.resp_valid}, 32'd0);
    check("abort_addr_zero", lif.address, 32'd0);
    check("abort_be_zero", {28'd0, lif.byteenable}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_cfg = 0;
    @(posedge clk);
    #1;
    check("ready_after_release", {31'd0, lif.req_ready}, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    lif.req_valid = 1'b0;
    lif.req_op    = '0;
    lif.req_addr  = '0;
    lif.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, lif.req_ready}, 32'd1);
    check("rst_read", {31'd0, lif.read}, 32'd0);
    check("rst_write", {31'd0, lif.write}, 32'd0);
    check("rst_resp_valid", {31'd0, lif.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, lif.resp_err}, 32'd0);
    check("rst_resp_rdata", lif.resp_rdata, 32'd0);
    check("rst_address", lif.address, 32'd0);
    check("rst_writedata", lif.writedata, 32'd0);
    check("rst_byteenable", {28'd0, lif.byteenable}, 32'd0);
    reset = 1'b1;

    // op, addr, wdata, readdata, waits, exp rdata, err, latency, bus?, bus addr, be, wdata
    txn(3'd5, 32'hBFC0_0031, 32'h0000_00F3, 32'd0, 0, 32'd0, 1'b0, 2, 1'b1, 32'hBFC0_0030, 4'b0010, 32'hF3F3_F3F3);
    txn(3'd0, 32'hBFC0_002C, 32'd0, 32'h0000_00F3, 0, 32'hFFFF_FFF3, 1'b0, 3, 1'b1, 32'hBFC0_002C, 4'b1111, 32'd0);
    txn(3'd1, 32'hBFC0_002C, 32'd0, 32'h0000_00F3, 0, 32'h0000_00F3, 1'b0, 3, 1'b1, 32'hBFC0_002C, 4'b1111, 32'd0);
    txn(3'd7, 32'hBFC0_0010, 32'h1234_5678, 32'd0, 3, 32'd0, 1'b0, 5, 1'b1, 32'hBFC0_0010, 4'b1111, 32'h1234_5678);
    txn(3'd2, 32'hBFC0_0002, 32'd0, 32'h8001_1234, 0, 32'hFFFF_8001, 1'b0, 3, 1'b1, 32'hBFC0_0000, 4'b1111, 32'd0);
    txn(3'd3, 32'hBFC0_0002, 32'd0, 32'h8001_1234, 0, 32'h0000_8001, 1'b0, 3, 1'b1, 32'hBFC0_0000, 4'b1111, 32'd0);
    txn(3'd0, 32'h1000_0001, 32'd0, 32'h0000_7F00, 0, 32'h0000_007F, 1'b0, 3, 1'b1, 32'h1000_0000, 4'b1111, 32'd0);
    txn(3'd0, 32'h1000_0003, 32'd0, 32'h8000_0000, 0, 32'hFFFF_FF80, 1'b0, 3, 1'b1, 32'h1000_0000, 4'b1111, 32'd0);
    txn(3'd1, 32'h1000_0006, 32'd0, 32'h00AB_0000, 0, 32'h0000_00AB, 1'b0, 3, 1'b1, 32'h1000_0004, 4'b1111, 32'd0);
    txn(3'd3, 32'h2000_0000, 32'd0, 32'h1234_FEDC, 2, 32'h0000_FEDC, 1'b0, 5, 1'b1, 32'h2000_0000, 4'b1111, 32'd0);
    txn(3'd2, 32'h2000_0000, 32'd0, 32'h0000_FEDC, 0, 32'hFFFF_FEDC, 1'b0, 3, 1'b1, 32'h2000_0000, 4'b1111, 32'd0);
    txn(3'd5, 32'h3000_0003, 32'h1234_5678, 32'd0, 1, 32'd0, 1'b0, 3, 1'b1, 32'h3000_0000, 4'b1000, 32'h7878_7878);
    txn(3'd6, 32'h3000_0002, 32'hABCD_1234, 32'd0, 0, 32'd0, 1'b0, 2, 1'b1, 32'h3000_0000, 4'b1100, 32'h1234_1234);
    txn(3'd4, 32'h4000_0008, 32'd0, 32'h0BAD_CAFE, 0, 32'h0BAD_CAFE, 1'b0, 3, 1'b1, 32'h4000_0008, 4'b1111, 32'd0);
`ifdef LSU_ALIGN_CHECK_EN
    txn(3'd4, 32'hBFC0_0006, 32'd0, 32'hCAFE_F00D, 0, 32'd0, 1'b1, 1, 1'b0, 32'd0, 4'd0, 32'd0);
    txn(3'd6, 32'hBFC0_0041, 32'h0000_BEEF, 32'd0, 0, 32'd0, 1'b1, 1, 1'b0, 32'd0, 4'd0, 32'd0);
    txn(3'd3, 32'hBFC0_0043, 32'd0, 32'h1111_2222, 0, 32'd0, 1'b1, 1, 1'b0, 32'd0, 4'd0, 32'd0);
`else
    txn(3'd4, 32'hBFC0_0006, 32'd0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 3, 1'b1, 32'hBFC0_0004, 4'b1111, 32'd0);
    txn(3'd6, 32'hBFC0_0041, 32'h0000_BEEF, 32'd0, 0, 32'd0, 1'b0, 2, 1'b1, 32'hBFC0_0040, 4'b0011, 32'hBEEF_BEEF);
    txn(3'd3, 32'hBFC0_0043, 32'd0, 32'h8888_2222, 0, 32'h0000_8888, 1'b0, 3, 1'b1, 32'hBFC0_0040, 4'b1111, 32'd0);
`endif

    abort_test();
    txn(3'd4, 32'h5000_0000, 32'd0, 32'h7654_3210, 0, 32'h7654_3210, 1'b0, 3, 1'b1, 32'h5000_0000, 4'b1111, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_resp_empty", rexp_q.size(), 32'd0);
    check("scoreboard_bus_empty", bexp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
